// File: rtl/car_warning_ctrl.sv
// Car warning controller: debounces door/ignition/belt switches and drives the alarm lamp and
// a pulsed chime, with a seat-belt grace period and driver mute until a new fault appears.
module car_warning_ctrl #(
   parameter int unsigned N_DOORS    = 4,
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned BELT_GRACE = 16,
   parameter int unsigned CHIME_ON   = 8,
   parameter int unsigned CHIME_OFF  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_DOORS-1:0] DoorClose,
   input  logic               Ignition,
   input  logic               SeatBelt,
   input  logic               Ack,
   output logic               Alarm,
   output logic               Chime,
   output logic [N_DOORS-1:0] DoorOpen,
   output logic [2:0]         State
);

   localparam int unsigned NCH  = N_DOORS + 2;
   localparam int unsigned DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam int unsigned GW   = (BELT_GRACE > 1) ? $clog2(BELT_GRACE + 1) : 1;
   localparam int unsigned CPER = CHIME_ON + CHIME_OFF;
   localparam int unsigned CW   = $clog2(CPER);

   // Channel order: doors in the low bits, then ignition, then seat belt.
   localparam logic [NCH-1:0] DEB_RST = {1'b1, 1'b0, {N_DOORS{1'b1}}};

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StGrace = 3'd2,
      StWarn  = 3'd3,
      StMute  = 3'd4
   } state_e;

   logic [NCH-1:0] raw;
   logic [NCH-1:0] deb_q;
   logic [NCH-1:0] deb_d;

   assign raw = {SeatBelt, Ignition, DoorClose};

   // ---------------------------------------------------------------------------------------
   // Debounce: one independent counter per channel
   // ---------------------------------------------------------------------------------------
   for (genvar i = 0; i < NCH; i++) begin : g_deb
      logic [DW-1:0] cnt_q;
      logic [DW-1:0] cnt_d;
      logic          val_d;

      always_comb begin
         cnt_d = '0;
         val_d = deb_q[i];
         if (raw[i] != deb_q[i]) begin
            if (cnt_q == DW'(DEB_CYCLES - 1)) begin
               val_d = raw[i];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign deb_d[i] = val_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_q <= DEB_RST;
      end else begin
         deb_q <= deb_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Fault decode
   // ---------------------------------------------------------------------------------------
   logic [N_DOORS-1:0] door_deb;
   logic               ign_deb;
   logic               belt_deb;
   logic [N_DOORS:0]   fault;
   logic               door_fault;
   logic               belt_fault;
   logic               any_fault;

   assign door_deb   = deb_q[N_DOORS-1:0];
   assign ign_deb    = deb_q[N_DOORS];
   assign belt_deb   = deb_q[N_DOORS+1];
   assign fault      = {~belt_deb, ~door_deb} & {(N_DOORS + 1){ign_deb}};
   assign door_fault = |fault[N_DOORS-1:0];
   assign belt_fault = fault[N_DOORS];
   assign any_fault  = |fault;

   // ---------------------------------------------------------------------------------------
   // FSM and counters
   // ---------------------------------------------------------------------------------------
   state_e           state_q;
   state_e           state_d;
   logic [GW-1:0]    grace_q;
   logic [GW-1:0]    grace_d;
   logic [CW-1:0]    chime_q;
   logic [CW-1:0]    chime_d;
   logic [N_DOORS:0] latch_q;
   logic [N_DOORS:0] latch_d;

   always_comb begin
      state_d = state_q;
      latch_d = latch_q;
      if (!ign_deb) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (door_fault) begin
                  state_d = StWarn;
               end else if (belt_fault) begin
                  state_d = StGrace;
               end else begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (door_fault) begin
                  state_d = StWarn;
               end else if (belt_fault) begin
                  state_d = StGrace;
               end
            end
            StGrace: begin
               // A fastened belt wins over a grace expiry on the same edge.
               if (door_fault) begin
                  state_d = StWarn;
               end else if (!belt_fault) begin
                  state_d = StRun;
               end else if (grace_q == GW'(BELT_GRACE - 1)) begin
                  state_d = StWarn;
               end
            end
            StWarn: begin
               if (!any_fault) begin
                  state_d = StRun;
               end else if (Ack) begin
                  state_d = StMute;
                  latch_d = fault;
               end
            end
            StMute: begin
               // Cleared fault bits drop out of the latch, so a reasserting fault counts as new.
               latch_d = latch_q & fault;
               if (!any_fault) begin
                  state_d = StRun;
               end else if ((fault & ~latch_q) != '0) begin
                  state_d = StWarn;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      grace_d = '0;
      if (state_q == StGrace && state_d == StGrace) begin
         grace_d = grace_q + 1'b1;
      end
   end

   always_comb begin
      chime_d = '0;
      if (state_q == StWarn && state_d == StWarn) begin
         chime_d = (chime_q == CW'(CPER - 1)) ? '0 : chime_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grace_q <= '0;
         chime_q <= '0;
         latch_q <= '0;
      end else begin
         state_q <= state_d;
         grace_q <= grace_d;
         chime_q <= chime_d;
         latch_q <= latch_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Outputs, decoded straight from registered state
   // ---------------------------------------------------------------------------------------
   assign Alarm    = (state_q == StWarn) || (state_q == StMute);
   assign Chime    = (state_q == StWarn) && (chime_q < CW'(CHIME_ON));
   assign DoorOpen = ~door_deb;
   assign State    = state_q;

endmodule

// File: tb/tb_car_warning_ctrl.sv
// Directed bench for car_warning_ctrl: default-parameter instance plus a minimal-parameter
// instance (1 door, 1-cycle debounce/grace/chime phases).
module tb_car_warning_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] DoorClose;
   logic       Ignition;
   logic       SeatBelt;
   logic       Ack;
   logic       Alarm;
   logic       Chime;
   logic [3:0] DoorOpen;
   logic [2:0] State;

   logic       s_door;
   logic       s_ign;
   logic       s_belt;
   logic       s_ack;
   logic       s_alarm;
   logic       s_chime;
   logic       s_open;
   logic [2:0] s_state;

   int vectors;
   int miscompares;

   car_warning_ctrl #(
      .N_DOORS   (4),
      .DEB_CYCLES(4),
      .BELT_GRACE(16),
      .CHIME_ON  (8),
      .CHIME_OFF (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .DoorClose(DoorClose),
      .Ignition (Ignition),
      .SeatBelt (SeatBelt),
      .Ack      (Ack),
      .Alarm    (Alarm),
      .Chime    (Chime),
      .DoorOpen (DoorOpen),
      .State    (State)
   );

   car_warning_ctrl #(
      .N_DOORS   (1),
      .DEB_CYCLES(1),
      .BELT_GRACE(1),
      .CHIME_ON  (1),
      .CHIME_OFF (1)
   ) dut_s (
      .clk      (clk),
      .rst_n    (rst_n),
      .DoorClose(s_door),
      .Ignition (s_ign),
      .SeatBelt (s_belt),
      .Ack      (s_ack),
      .Alarm    (s_alarm),
      .Chime    (s_chime),
      .DoorOpen (s_open),
      .State    (s_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit for driving and sampling.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(2);
      vectors++;
      if (Alarm !== 1'b0) begin miscompares++; $display("FAIL rst_alarm got %b exp 0", Alarm); end
      vectors++;
      if (Chime !== 1'b0) begin miscompares++; $display("FAIL rst_chime got %b exp 0", Chime); end
      vectors++;
      if (DoorOpen !== 4'b0000) begin
         miscompares++; $display("FAIL rst_dooropen got %b exp 0000", DoorOpen);
      end
      vectors++;
      if (State !== 3'd0) begin miscompares++; $display("FAIL rst_state got %0d exp 0", State); end
      vectors++;
      if (s_state !== 3'd0 || s_alarm !== 1'b0 || s_open !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_sweep got st=%0d al=%b op=%b exp 0 0 0", s_state, s_alarm, s_open);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_ignition_on();
      Ignition = 1'b1;
      tick(4);
      vectors++;
      if (State !== 3'd0) begin miscompares++; $display("FAIL ign_early got %0d exp 0", State); end
      tick(1);
      vectors++;
      if (State !== 3'd1) begin miscompares++; $display("FAIL ign_run got %0d exp 1", State); end
   endtask

   task automatic test_glitch();
      DoorClose = 4'b1110;
      tick(3);
      DoorClose = 4'b1111;
      tick(5);
      vectors++;
      if (DoorOpen !== 4'b0000) begin
         miscompares++; $display("FAIL glitch_open got %b exp 0000", DoorOpen);
      end
      vectors++;
      if (State !== 3'd1) begin miscompares++; $display("FAIL glitch_state got %0d exp 1", State); end
      vectors++;
      if (Alarm !== 1'b0) begin miscompares++; $display("FAIL glitch_alarm got %b exp 0", Alarm); end
   endtask

   task automatic test_door_alarm();
      DoorClose = 4'b1011;
      tick(4);
      vectors++;
      if (DoorOpen !== 4'b0100) begin
         miscompares++; $display("FAIL door_open got %b exp 0100", DoorOpen);
      end
      vectors++;
      if (State !== 3'd1) begin miscompares++; $display("FAIL door_pre got %0d exp 1", State); end
      tick(1);
      vectors++;
      if (State !== 3'd3) begin miscompares++; $display("FAIL door_warn got %0d exp 3", State); end
      vectors++;
      if (Alarm !== 1'b1) begin miscompares++; $display("FAIL door_alarm got %b exp 1", Alarm); end
      for (int k = 0; k < 32; k++) begin
         vectors++;
         if (Chime !== ((k % 16) < 8)) begin
            miscompares++; $display("FAIL door_chime k=%0d got %b exp %b", k, Chime, (k % 16) < 8);
         end
         tick(1);
      end
      DoorClose = 4'b1111;
      tick(5);
      vectors++;
      if (State !== 3'd1 || Alarm !== 1'b0) begin
         miscompares++; $display("FAIL door_clear got st=%0d al=%b exp 1 0", State, Alarm);
      end
   endtask

   task automatic test_belt_grace();
      SeatBelt = 1'b0;
      tick(5);
      vectors++;
      if (State !== 3'd2) begin miscompares++; $display("FAIL grace_enter got %0d exp 2", State); end
      tick(15);
      vectors++;
      if (State !== 3'd2) begin miscompares++; $display("FAIL grace_hold got %0d exp 2", State); end
      tick(1);
      vectors++;
      if (State !== 3'd3 || Alarm !== 1'b1) begin
         miscompares++; $display("FAIL grace_warn got st=%0d al=%b exp 3 1", State, Alarm);
      end
   endtask

   task automatic test_mute();
      Ack = 1'b1;
      tick(1);
      Ack = 1'b0;
      vectors++;
      if (State !== 3'd4 || Chime !== 1'b0 || Alarm !== 1'b1) begin
         miscompares++;
         $display("FAIL mute_enter got st=%0d ch=%b al=%b exp 4 0 1", State, Chime, Alarm);
      end
      tick(3);
      vectors++;
      if (State !== 3'd4) begin miscompares++; $display("FAIL mute_hold got %0d exp 4", State); end
      DoorClose = 4'b1101;
      tick(4);
      vectors++;
      if (State !== 3'd4) begin miscompares++; $display("FAIL mute_pre got %0d exp 4", State); end
      tick(1);
      vectors++;
      if (State !== 3'd3 || Chime !== 1'b1 || DoorOpen !== 4'b0010) begin
         miscompares++;
         $display("FAIL mute_newfault got st=%0d ch=%b op=%b exp 3 1 0010", State, Chime, DoorOpen);
      end
      DoorClose = 4'b1111;
      SeatBelt  = 1'b1;
      tick(5);
      vectors++;
      if (State !== 3'd1 || Alarm !== 1'b0 || Chime !== 1'b0) begin
         miscompares++;
         $display("FAIL mute_clear got st=%0d al=%b ch=%b exp 1 0 0", State, Alarm, Chime);
      end
   endtask

   task automatic test_ack_with_clear();
      DoorClose = 4'b1110;
      tick(5);
      vectors++;
      if (State !== 3'd3) begin miscompares++; $display("FAIL ackclr_warn got %0d exp 3", State); end
      DoorClose = 4'b1111;
      tick(4);
      Ack = 1'b1;
      tick(1);
      Ack = 1'b0;
      vectors++;
      if (State !== 3'd1) begin miscompares++; $display("FAIL ackclr_run got %0d exp 1", State); end
   endtask

   task automatic test_grace_fasten();
      SeatBelt = 1'b0;
      tick(5);
      tick(9);
      SeatBelt = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         vectors++;
         if (Alarm !== 1'b0) begin
            miscompares++; $display("FAIL fasten10_alarm k=%0d got %b exp 0", k, Alarm);
         end
      end
      vectors++;
      if (State !== 3'd1) begin miscompares++; $display("FAIL fasten10_run got %0d exp 1", State); end
      // Belt debounces on the same edge the grace count expires.
      SeatBelt = 1'b0;
      tick(5);
      tick(11);
      SeatBelt = 1'b1;
      tick(4);
      vectors++;
      if (State !== 3'd2) begin miscompares++; $display("FAIL fasten_edge_pre got %0d exp 2", State); end
      tick(1);
      vectors++;
      if (State !== 3'd1 || Alarm !== 1'b0) begin
         miscompares++; $display("FAIL fasten_edge got st=%0d al=%b exp 1 0", State, Alarm);
      end
   endtask

   task automatic test_ignition_off_reset();
      DoorClose = 4'b0111;
      tick(5);
      vectors++;
      if (State !== 3'd3) begin miscompares++; $display("FAIL ignoff_warn got %0d exp 3", State); end
      Ignition = 1'b0;
      tick(4);
      vectors++;
      if (State !== 3'd3) begin miscompares++; $display("FAIL ignoff_pre got %0d exp 3", State); end
      tick(1);
      vectors++;
      if (State !== 3'd0 || Alarm !== 1'b0 || DoorOpen !== 4'b1000) begin
         miscompares++;
         $display("FAIL ignoff_idle got st=%0d al=%b op=%b exp 0 0 1000", State, Alarm, DoorOpen);
      end
      Ignition = 1'b1;
      tick(5);
      vectors++;
      if (State !== 3'd3) begin miscompares++; $display("FAIL rstmid_warn got %0d exp 3", State); end
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      vectors++;
      if (State !== 3'd0 || Alarm !== 1'b0 || Chime !== 1'b0 || DoorOpen !== 4'b0000) begin
         miscompares++;
         $display("FAIL rstmid_out got st=%0d al=%b ch=%b op=%b exp 0 0 0 0000",
                  State, Alarm, Chime, DoorOpen);
      end
      tick(4);
      vectors++;
      if (State !== 3'd0 || DoorOpen !== 4'b1000) begin
         miscompares++; $display("FAIL rstmid_deb got st=%0d op=%b exp 0 1000", State, DoorOpen);
      end
      tick(1);
      vectors++;
      if (State !== 3'd3 || Alarm !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_rewarn got st=%0d al=%b exp 3 1", State, Alarm);
      end
      DoorClose = 4'b1111;
      Ignition  = 1'b0;
      tick(6);
   endtask

   task automatic test_sweep();
      s_ign  = 1'b1;
      s_belt = 1'b0;
      tick(1);
      vectors++;
      if (s_state !== 3'd0) begin miscompares++; $display("FAIL sw_idle got %0d exp 0", s_state); end
      tick(1);
      vectors++;
      if (s_state !== 3'd2) begin miscompares++; $display("FAIL sw_grace got %0d exp 2", s_state); end
      tick(1);
      vectors++;
      if (s_state !== 3'd3 || s_chime !== 1'b1 || s_alarm !== 1'b1) begin
         miscompares++;
         $display("FAIL sw_warn got st=%0d ch=%b al=%b exp 3 1 1", s_state, s_chime, s_alarm);
      end
      tick(1);
      vectors++;
      if (s_chime !== 1'b0) begin miscompares++; $display("FAIL sw_chime1 got %b exp 0", s_chime); end
      tick(1);
      vectors++;
      if (s_chime !== 1'b1) begin miscompares++; $display("FAIL sw_chime2 got %b exp 1", s_chime); end
      s_door = 1'b0;
      tick(1);
      vectors++;
      if (s_open !== 1'b1 || s_state !== 3'd3) begin
         miscompares++; $display("FAIL sw_door got op=%b st=%0d exp 1 3", s_open, s_state);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      DoorClose   = 4'b1111;
      Ignition    = 1'b0;
      SeatBelt    = 1'b1;
      Ack         = 1'b0;
      s_door      = 1'b1;
      s_ign       = 1'b0;
      s_belt      = 1'b1;
      s_ack       = 1'b0;

      test_reset();
      test_ignition_on();
      test_glitch();
      test_door_alarm();
      test_belt_grace();
      test_mute();
      test_ack_with_clear();
      test_grace_fasten();
      test_ignition_off_reset();
      test_sweep();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
